// File: rtl/afe_spi_pkg.sv
// Shared types and default timing for the AFE attenuator SPI arbiter.
// Owner encoding doubles as the "last grant" flag.
package afe_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    LATCH,
    GAP
  } spi_state_e;

  typedef enum logic {
    OWNER_CPU  = 1'b0,
    OWNER_AUTO = 1'b1
  } owner_e;

  localparam int unsigned DEF_NUM_AFE     = 2;
  localparam int unsigned DEF_DATA_WIDTH  = 16;
  localparam int unsigned DEF_HALF_PERIOD = 25;
  localparam int unsigned DEF_LE_HALVES   = 2;

  function automatic int unsigned xfer_cycles(
    input int unsigned dw,
    input int unsigned hp,
    input int unsigned le
  );
    return (2 + 2 * dw + le) * hp;
  endfunction

endpackage

// File: rtl/afe_spi_shifter.sv
// Single-lane SPI serialiser: half-period ticker, MSB-first shifter,
// latch-enable pulse and trailing gap.
module afe_spi_shifter
  import afe_spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned HALF_PERIOD = DEF_HALF_PERIOD,
  parameter int unsigned LE_HALVES   = DEF_LE_HALVES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk,
  output logic                  sdi,
  output logic                  le
);

  localparam int unsigned CW =
    (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
  localparam int unsigned LW = $clog2(LE_HALVES + 1);

  spi_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic [BW-1:0]         bit_q;
  logic [LW-1:0]         le_q;
  logic [DATA_WIDTH-1:0] sreg_q;
  logic                  tick;

  assign tick = (cnt_q == CW'(HALF_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start) state_d = SETUP;
      SETUP:    if (tick) state_d = SHIFT_HI;
      SHIFT_HI: if (tick) state_d = SHIFT_LO;
      SHIFT_LO:
        if (tick)
          state_d = (bit_q == BW'(DATA_WIDTH)) ? LATCH : SHIFT_HI;
      LATCH:
        if (tick && le_q == LW'(LE_HALVES - 1)) state_d = GAP;
      GAP:      if (tick) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Counter is cleared on every tick, so each state entry restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      bit_q  <= '0;
      le_q   <= '0;
      sreg_q <= '0;
    end else begin
      cnt_q <= (state_q == IDLE || tick) ? '0 : cnt_q + CW'(1);
      if (state_q == IDLE && start) begin
        sreg_q <= data;
        bit_q  <= '0;
        le_q   <= '0;
      end
      if (state_q == SHIFT_HI && tick) begin
        sreg_q <= sreg_q << 1;
        bit_q  <= bit_q + BW'(1);
      end
      if (state_q == LATCH && tick) begin
        le_q <= le_q + LW'(1);
      end
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == GAP) && tick;
    sclk = (state_q == SHIFT_HI);
    le   = (state_q == LATCH);
    sdi  = 1'b0;
    unique case (1'b1)
      (state_q == SETUP),
      (state_q == SHIFT_HI),
      (state_q == SHIFT_LO): sdi = sreg_q[DATA_WIDTH-1];
      default:               sdi = 1'b0;
    endcase
  end

endmodule

// File: rtl/afe_spi_arbiter.sv
// Round-robin arbiter between CPU writes and auto-gain for the
// per-AFE attenuator SPI lanes; one shared shifter is demuxed per lane.
module afe_spi_arbiter
  import afe_spi_pkg::*;
#(
  parameter int unsigned NUM_AFE     = DEF_NUM_AFE,
  parameter int unsigned SEL_WIDTH   = 1,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned HALF_PERIOD = DEF_HALF_PERIOD,
  parameter int unsigned LE_HALVES   = DEF_LE_HALVES
) (
  input  logic                  sysClk,
  input  logic                  sysRst_n,
  input  logic                  cpuWrStrobe,
  input  logic [SEL_WIDTH-1:0]  cpuAfeSel,
  input  logic [DATA_WIDTH-1:0] cpuData,
  output logic                  cpuBusy,
  input  logic                  autoReq,
  input  logic [SEL_WIDTH-1:0]  autoAfeSel,
  input  logic [DATA_WIDTH-1:0] autoData,
  output logic                  autoGnt,
  output logic                  autoDone,
  output logic                  lastGrantAuto,
  output logic                  selErr,
  output logic [NUM_AFE-1:0]    AFE_SPI_CLK,
  output logic [NUM_AFE-1:0]    AFE_SPI_SDI,
  output logic [NUM_AFE-1:0]    AFE_SPI_LE
);

  logic                  cpu_pend_q;
  logic [SEL_WIDTH-1:0]  cpu_sel_q;
  logic [DATA_WIDTH-1:0] cpu_data_q;
  owner_e                owner_q;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic                  sel_err_q;
  logic                  auto_gnt_q;
  logic                  auto_err_q;
  logic                  auto_done_q;

  logic                  busy, done, sclk, sdi, le;
  logic                  cpu_req, auto_req;
  logic [SEL_WIDTH-1:0]  cpu_sel, gnt_sel;
  logic [DATA_WIDTH-1:0] cpu_data, gnt_data;
  logic                  gnt_cpu, gnt_auto, gnt_any, gnt_bad, start;

  // A fresh strobe competes in its own cycle and carries the newest word.
  assign cpu_req  = cpu_pend_q | cpuWrStrobe;
  assign cpu_sel  = cpuWrStrobe ? cpuAfeSel : cpu_sel_q;
  assign cpu_data = cpuWrStrobe ? cpuData : cpu_data_q;
  // Requester still holds autoReq while it sees autoGnt; ignore it then.
  assign auto_req = autoReq & ~auto_gnt_q;

  assign gnt_cpu  = ~busy & cpu_req &
                    (~auto_req | (owner_q == OWNER_AUTO));
  assign gnt_auto = ~busy & auto_req &
                    (~cpu_req | (owner_q == OWNER_CPU));
  assign gnt_any  = gnt_cpu | gnt_auto;
  assign gnt_sel  = gnt_auto ? autoAfeSel : cpu_sel;
  assign gnt_data = gnt_auto ? autoData : cpu_data;
  assign gnt_bad  = gnt_any & (32'(gnt_sel) >= NUM_AFE);
  assign start    = gnt_any & ~gnt_bad;

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      cpu_pend_q  <= 1'b0;
      cpu_sel_q   <= '0;
      cpu_data_q  <= '0;
      owner_q     <= OWNER_AUTO;
      sel_q       <= '0;
      sel_err_q   <= 1'b0;
      auto_gnt_q  <= 1'b0;
      auto_err_q  <= 1'b0;
      auto_done_q <= 1'b0;
    end else begin
      if (cpuWrStrobe && !gnt_cpu) begin
        cpu_pend_q <= 1'b1;
        cpu_sel_q  <= cpuAfeSel;
        cpu_data_q <= cpuData;
      end else if (gnt_cpu) begin
        cpu_pend_q <= 1'b0;
      end
      if (gnt_any) owner_q <= gnt_auto ? OWNER_AUTO : OWNER_CPU;
      if (start) sel_q <= gnt_sel;
      if (gnt_bad) sel_err_q <= 1'b1;
      else if (cpuWrStrobe) sel_err_q <= 1'b0;
      auto_gnt_q  <= gnt_auto;
      auto_err_q  <= gnt_auto & gnt_bad;
      auto_done_q <= (done & (owner_q == OWNER_AUTO)) | auto_err_q;
    end
  end

  afe_spi_shifter #(
    .DATA_WIDTH  (DATA_WIDTH),
    .HALF_PERIOD (HALF_PERIOD),
    .LE_HALVES   (LE_HALVES)
  ) u_shifter (
    .clk   (sysClk),
    .rst_n (sysRst_n),
    .start (start),
    .data  (gnt_data),
    .busy  (busy),
    .done  (done),
    .sclk  (sclk),
    .sdi   (sdi),
    .le    (le)
  );

  always_comb begin
    AFE_SPI_CLK = '0;
    AFE_SPI_SDI = '0;
    AFE_SPI_LE  = '0;
    for (int i = 0; i < NUM_AFE; i++) begin
      if (sel_q == SEL_WIDTH'(i)) begin
        AFE_SPI_CLK[i] = sclk;
        AFE_SPI_SDI[i] = sdi;
        AFE_SPI_LE[i]  = le;
      end
    end
  end

  assign cpuBusy       = cpu_pend_q | (busy & (owner_q == OWNER_CPU));
  assign autoGnt       = auto_gnt_q;
  assign autoDone      = auto_done_q;
  assign lastGrantAuto = (owner_q == OWNER_AUTO);
  assign selErr        = sel_err_q;

endmodule

// File: doc/afe_spi_arbiter.md
Name: afe_spi_arbiter

Overview:
Shares the per-AFE write-only attenuator/switch SPI buses (AFE_SPI_CLK/SDI/LE, one lane per AFE) between two requesters: CPU register writes and the automatic attenuation (auto-gain) loop. It arbitrates round-robin, then serialises one word MSB-first on the selected AFE lane, followed by a latch-enable pulse. It sits in the sysClk domain, between the CSR block / auto-gain logic and the AFE_SPI_* top-level pins.

Parameters:
NUM_AFE, 2, number of AFE SPI lanes
SEL_WIDTH, 1, width of AFE select (>= clog2(NUM_AFE))
DATA_WIDTH, 16, bits per SPI word
HALF_PERIOD, 25, sysClk cycles per SCLK half period (100 MHz -> 2 MHz SCLK)
LE_HALVES, 2, LE high time in half periods

Ports:
sysClk  in  1  system clock
sysRst_n  in  1  asynchronous, active-low reset
cpuWrStrobe  in  1  one-cycle CPU write request
cpuAfeSel  in  SEL_WIDTH  CPU target AFE
cpuData  in  DATA_WIDTH  CPU word
cpuBusy  out  1  CPU request pending or CPU transfer active
autoReq  in  1  level request from auto-gain; held until autoGnt
autoAfeSel  in  SEL_WIDTH  auto target AFE; stable while autoReq is high
autoData  in  DATA_WIDTH  auto word; stable while autoReq is high
autoGnt  out  1  one-cycle pulse: auto request accepted, data captured
autoDone  out  1  one-cycle pulse: auto transfer finished (after GAP)
lastGrantAuto  out  1  status: 1 if the most recent grant went to auto
selErr  out  1  sticky: a request with select >= NUM_AFE was discarded; cleared by the next cpuWrStrobe
AFE_SPI_CLK  out  NUM_AFE  SCLK per lane, idle low
AFE_SPI_SDI  out  NUM_AFE  data per lane, idle low
AFE_SPI_LE  out  NUM_AFE  latch enable per lane, idle low

Behaviour:
- Reset: all outputs 0; CPU pending flag cleared; lastGrantAuto=1, so the CPU wins the first tie; FSM=IDLE. Reset asserted mid-transfer forces the pins low immediately (asynchronous) and the word is abandoned.
- CPU pending register: cpuWrStrobe loads sel/data and sets pending. A strobe while pending but not yet started overwrites the pending word. A strobe during an active CPU transfer becomes the next pending word. cpuBusy = pending | (active & owner==CPU).
- IDLE arbitration, evaluated every cycle:
  - Both requesting: grant the side not granted last.
  - One requesting: grant that side.
  - Grant cycle: capture sel/data into the shift register, update lastGrantAuto, clear CPU pending if the CPU was granted, pulse autoGnt if auto was granted.
  - If the captured sel >= NUM_AFE: set selErr, return to IDLE without shifting (autoDone still pulses one cycle later for an auto grant).
- FSM per granted word, with tick = HALF_PERIOD counter terminal count:
  - SETUP (1 half): SCLK low; SDI = data[MSB].
  - SHIFT_HI (1 half): SCLK high.
  - SHIFT_LO (1 half): SCLK low; SDI advances to the next bit at entry. Repeat for DATA_WIDTH bits; after the last bit's SHIFT_LO, go to LATCH.
  - LATCH (LE_HALVES halves): LE high, SDI low.
  - GAP (1 half): all low. Then IDLE; autoDone pulses on GAP exit when auto owned the transfer.
- Only the selected lane toggles; the other lanes stay at 0.
- Transfer length from the grant cycle to IDLE: (2 + 2*DATA_WIDTH + LE_HALVES) * HALF_PERIOD cycles = 900 at defaults. A new grant may occur in the first IDLE cycle.
- Half-period counter: restarts at each state entry; width is clog2(HALF_PERIOD); no wrap issues.
- autoReq dropped before autoGnt: no grant, no error.

Decomposition:
- Shared package/header afe_spi_pkg: FSM state encoding (IDLE, SETUP, SHIFT_HI, SHIFT_LO, LATCH, GAP), owner encoding (OWNER_CPU=0, OWNER_AUTO=1), default timing constants.
- One sub-module, afe_spi_shifter: half-period tick generator plus shift register/bit counter, exposing start/done and sclk/sdi/le for a single lane; the arbiter demuxes it onto the selected lane.

Test Plan:
- CPU only: write sel=1, data=0xA5C3 -> lane 1 shows 16 rising edges, sampled SDI=0xA5C3 MSB-first, LE high for 50 cycles, cpuBusy low 900 cycles after grant; lane 0 stays silent.
- Simultaneous cpuWrStrobe and autoReq after reset -> CPU granted first (lastGrantAuto=1); auto granted in the IDLE cycle after the CPU transfer; autoGnt/autoDone are one-cycle pulses.
- Round-robin: auto and CPU both continuously requesting for 4 transfers -> grant order CPU, auto, CPU, auto.
- CPU overwrite: two strobes (0x1111, then 0x2222) during an auto transfer -> only 0x2222 is shifted after it.
- Invalid sel=2 with NUM_AFE=2 -> no pin activity, selErr=1; the next cpuWrStrobe clears selErr.
- sysRst_n low at bit 7 of a transfer -> all pins 0 within the same cycle, no LE pulse, pending cleared; after release, IDLE and a fresh CPU request completes normally.
